// File: rtl/mem_burst_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_burst_pkg
//  Brief    : Shared types and constants for the burst memory stream front-end
//  Revision : 1.0 - initial release
// ============================================================================
package mem_burst_pkg;

  localparam int MEM_DW         = 16;
  localparam int MEM_AW         = 32;
  localparam int BYTES_PER_WORD = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ARM  = 3'd2,
    WAIT = 3'd3,
    REL  = 3'd4,
    FIN  = 3'd5
  } mbs_state_t;

  // The burst port increments before each word, so start one word early.
  function automatic logic [MEM_AW-1:0] pre_inc_addr(input logic [MEM_AW-1:0] addr);
    return addr - MEM_AW'(BYTES_PER_WORD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_burst_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_burst_stream_if
//  Brief    : Burst port signal bundle (stb/cyc start, seq four-phase words)
//  Revision : 1.0 - initial release
// ============================================================================
import mem_burst_pkg::*;

interface mem_burst_stream_if;
  logic              bs_stb_o;
  logic              bs_we_o;
  logic [MEM_AW-1:0] bs_addr_o;
  logic [15:0]       bs_len_o;
  logic              bs_seq_o;
  logic [MEM_DW-1:0] bs_dat_o;
  logic              bs_cyc_i;
  logic              bs_seq_i;
  logic [MEM_DW-1:0] bs_dat_i;

  // Stream front-end side: drives requests, observes completions.
  modport master (
    output bs_stb_o, bs_we_o, bs_addr_o, bs_len_o, bs_seq_o, bs_dat_o,
    input  bs_cyc_i, bs_seq_i, bs_dat_i
  );

  // Burst port side.
  modport slave (
    input  bs_stb_o, bs_we_o, bs_addr_o, bs_len_o, bs_seq_o, bs_dat_o,
    output bs_cyc_i, bs_seq_i, bs_dat_i
  );
endinterface
`default_nettype wire

// File: rtl/mem_burst_stream_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO, head word shown combinationally, 0 when empty
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  wire logic                     clk_i,
  input  wire logic                     rst_ni,
  input  wire logic                     push_i,
  input  wire logic [WIDTH-1:0]         din_i,
  input  wire logic                     pop_i,
  output logic      [WIDTH-1:0]         dout_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic      [$clog2(DEPTH):0]   count_o
);

  localparam int                c_aw   = $clog2(DEPTH);
  localparam logic [c_aw:0]     c_full = (c_aw+1)'(DEPTH);
  localparam logic [c_aw-1:0]   c_one  = c_aw'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_aw:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is only taken when a pop frees the slot this cycle.
  assign w_pop   = pop_i & (r_count != '0);
  assign w_push  = push_i & ((r_count != c_full) | w_pop);

  assign full_o  = (r_count == c_full);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign dout_o  = empty_o ? '0 : r_mem[r_rptr];

  // Storage array, no reset needed: contents are qualified by the count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= din_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_one;
      if (w_pop)  r_rptr <= r_rptr + c_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_burst_stream.sv
`default_nettype none
// ============================================================================
//  Module   : mem_burst_stream
//  Brief    : Command/stream front-end for the 16-bit burst memory port
//  Revision : 1.0 - initial release
// ============================================================================
import mem_burst_pkg::*;

module mem_burst_stream #(
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  input  wire logic              cmd_valid_i,
  output logic                   cmd_ready_o,
  input  wire logic              cmd_read_i,
  input  wire logic [MEM_AW-1:0] cmd_addr_i,
  input  wire logic [15:0]       cmd_len_i,
  input  wire logic              wr_valid_i,
  output logic                   wr_ready_o,
  input  wire logic [MEM_DW-1:0] wr_data_i,
  output logic                   rd_valid_o,
  input  wire logic              rd_ready_i,
  output logic      [MEM_DW-1:0] rd_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  mem_burst_stream_if.master     bs
);

  localparam int            c_aw    = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0] c_depth = (c_aw+1)'(FIFO_DEPTH);

  mbs_state_t        r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_stb;
  logic              r_we;
  logic [MEM_AW-1:0] r_addr;
  logic [15:0]       r_len;
  logic              r_seq;
  logic [MEM_DW-1:0] r_dat;
  logic [14:0]       r_cnt;

  logic              w_accept;
  logic [14:0]       w_nwords;
  logic              w_wf_pop;
  logic              w_wf_empty;
  logic              w_wf_full;
  logic [MEM_DW-1:0] w_wf_dout;
  logic [c_aw:0]     w_wf_count;
  logic              w_rf_push;
  logic              w_rf_empty;
  logic              w_rf_full;
  logic [c_aw:0]     w_rf_count;
  logic              w_rd_room;
  logic              w_unused;

  assign w_accept  = cmd_valid_i & (r_state == IDLE);
  assign w_nwords  = cmd_len_i[15:1];
  assign w_wf_pop  = (r_state == ARM) & ~r_we & ~w_wf_empty;
  assign w_rf_push = (r_state == WAIT) & r_we & bs.bs_seq_i;
  // At most one word is in flight, and it is only requested from ARM.
  assign w_rd_room = (w_rf_count < c_depth);
  assign w_unused  = ^{cmd_len_i[0], w_rf_full, w_wf_count};

  assign cmd_ready_o  = (r_state == IDLE);
  assign wr_ready_o   = ~w_wf_full;
  assign rd_valid_o   = ~w_rf_empty;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign bs.bs_stb_o  = r_stb;
  assign bs.bs_we_o   = r_we;
  assign bs.bs_addr_o = r_addr;
  assign bs.bs_len_o  = r_len;
  assign bs.bs_seq_o  = r_seq;
  assign bs.bs_dat_o  = r_dat;

  sync_fifo #(.WIDTH(MEM_DW), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wr_valid_i),
    .din_i   (wr_data_i),
    .pop_i   (w_wf_pop),
    .dout_o  (w_wf_dout),
    .full_o  (w_wf_full),
    .empty_o (w_wf_empty),
    .count_o (w_wf_count)
  );

  sync_fifo #(.WIDTH(MEM_DW), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_rf_push),
    .din_i   (bs.bs_dat_i),
    .pop_i   (rd_ready_i),
    .dout_o  (rd_data_o),
    .full_o  (w_rf_full),
    .empty_o (w_rf_empty),
    .count_o (w_rf_count)
  );

  // Command sequencer: burst start, per-word four-phase handshake, completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_seq   <= 1'b0;
      r_dat   <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_nwords == '0) begin
              // Zero-length command completes without touching the port.
              r_done <= 1'b1;
            end else begin
              r_cnt   <= w_nwords;
              r_addr  <= pre_inc_addr(cmd_addr_i);
              r_len   <= {w_nwords, 1'b0};
              r_we    <= cmd_read_i;
              r_stb   <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          if (bs.bs_cyc_i) begin
            r_stb   <= 1'b0;
            r_state <= ARM;
          end
        end
        ARM: begin
          if (r_we ? w_rd_room : ~w_wf_empty) begin
            if (!r_we) r_dat <= w_wf_dout;
            r_seq   <= 1'b1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (bs.bs_seq_i) begin
            r_cnt   <= r_cnt - 15'd1;
            r_seq   <= 1'b0;
            r_state <= REL;
          end
        end
        REL: begin
          if (!bs.bs_seq_i) begin
            r_dat   <= '0;
            r_state <= (r_cnt != '0) ? ARM : FIN;
          end
        end
        FIN: begin
          if (!bs.bs_cyc_i) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_burst_stream
//  Brief    : Directed bench with a small burst-port RAM model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_burst_stream;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_read_i;
  logic [31:0] cmd_addr_i;
  logic [15:0] cmd_len_i;
  logic        wr_valid_i, rd_ready_i;
  logic [15:0] wr_data_i;
  logic        cmd_ready_o, wr_ready_o, rd_valid_o, busy_o, done_o;
  logic [15:0] rd_data_o;

  mem_burst_stream_if bus();

  mem_burst_stream #(.FIFO_DEPTH(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_read_i  (cmd_read_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_data_i   (wr_data_i),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i),
    .rd_data_o   (rd_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .bs          (bus)
  );

  always #5 clk_i = ~clk_i;

  int          n_total = 0;
  int          n_bad   = 0;
  int          done_cnt = 0;
  int          stb_cnt  = 0;
  int          seq_rise = 0;
  logic        prev_seq = 1'b0;
  logic [15:0] rq[$];
  logic [15:0] ram [0:255];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Observers, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (bus.bs_stb_o) stb_cnt++;
    if (bus.bs_seq_o && !prev_seq) seq_rise++;
    prev_seq = bus.bs_seq_o;
    if (rd_valid_o && rd_ready_i) rq.push_back(rd_data_o);
  end

  // Burst-port model: pre-incrementing address, four-phase word handshake.
  int          m_state = 0;
  int          m_left;
  logic [31:0] m_addr;
  logic        m_we;
  initial begin
    bus.bs_cyc_i = 1'b0;
    bus.bs_seq_i = 1'b0;
    bus.bs_dat_i = 16'h0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        bus.bs_cyc_i = 1'b0;
        bus.bs_seq_i = 1'b0;
        bus.bs_dat_i = 16'h0;
        m_state = 0;
      end else begin
        case (m_state)
          0: if (bus.bs_stb_o) begin
               m_addr = bus.bs_addr_o;
               m_left = int'(bus.bs_len_o >> 1);
               m_we   = bus.bs_we_o;
               bus.bs_cyc_i = 1'b1;
               m_state = 1;
             end
          1: if (bus.bs_seq_o) begin
               m_addr = m_addr + 32'd2;
               if (m_we) bus.bs_dat_i = ram[m_addr[8:1]];
               else      ram[m_addr[8:1]] = bus.bs_dat_o;
               bus.bs_seq_i = 1'b1;
               m_state = 2;
             end
          2: if (!bus.bs_seq_o) begin
               bus.bs_seq_i = 1'b0;
               m_left--;
               m_state = (m_left == 0) ? 3 : 1;
             end
          default: begin
               bus.bs_cyc_i = 1'b0;
               m_state = 0;
             end
        endcase
      end
    end
  end

  // Issue one command; returns 1 time unit after the accepting edge.
  task automatic send_cmd(input logic rd, input logic [31:0] addr, input logic [15:0] len);
    @(negedge clk_i);
    chk("cmd_ready", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_read_i  = rd;
    cmd_addr_i  = addr;
    cmd_len_i   = len;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget && done_cnt == start; i++) @(negedge clk_i);
    @(negedge clk_i);
    chk("done_once", 32'(done_cnt - start), 32'd1);
  endtask

  task automatic push_wr(input logic [15:0] d);
    @(negedge clk_i);
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    @(negedge clk_i);
    wr_valid_i = 1'b0;
  endtask

  initial begin
    int s;
    rst_ni = 1'b1;
    cmd_valid_i = 1'b0; cmd_read_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    wr_valid_i = 1'b0; wr_data_i = '0; rd_ready_i = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0;
    for (int i = 0; i < 20; i++) ram[32 + i] = 16'hA000 + 16'(i);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_wr_ready",  32'(wr_ready_o),  32'd1);
    chk("rst_outs", 32'({busy_o, done_o, rd_valid_o, bus.bs_stb_o, bus.bs_seq_o}), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Write 4 prefilled words to 0x10.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      wr_valid_i = 1'b1;
      wr_data_i  = 16'h1111 * 16'(i + 1);
    end
    @(negedge clk_i);
    wr_valid_i = 1'b0;
    send_cmd(1'b0, 32'h10, 16'd8);
    chk("wr_stb_latency", 32'(bus.bs_stb_o), 32'd1);
    chk("wr_busy", 32'(busy_o), 32'd1);
    chk("wr_addr", bus.bs_addr_o, 32'h0E);
    chk("wr_len", 32'(bus.bs_len_o), 32'd8);
    chk("wr_we", 32'(bus.bs_we_o), 32'd0);
    wait_done(200);
    chk("wr_busy_after", 32'(busy_o), 32'd0);
    for (int i = 0; i < 4; i++) chk("wr_ram", 32'(ram[8 + i]), 32'h1111 * 32'(i + 1));

    // Read back the same region with a ready consumer.
    @(posedge clk_i); #1 rd_ready_i = 1'b1;
    rq.delete();
    send_cmd(1'b1, 32'h10, 16'd8);
    wait_done(200);
    repeat (4) @(negedge clk_i);
    chk("rb_count", 32'(rq.size()), 32'd4);
    for (int i = 0; i < 4 && i < rq.size(); i++) chk("rb_data", 32'(rq[i]), 32'h1111 * 32'(i + 1));
    chk("rb_valid_low", 32'(rd_valid_o), 32'd0);

    // 20-word read with a stalled consumer: port must stop after 8 words.
    @(posedge clk_i); #1 rd_ready_i = 1'b0;
    rq.delete();
    s = seq_rise;
    send_cmd(1'b1, 32'h40, 16'd40);
    repeat (200) @(negedge clk_i);
    chk("stall_seq_rises", 32'(seq_rise - s), 32'd8);
    chk("stall_valid", 32'(rd_valid_o), 32'd1);
    chk("stall_busy", 32'(busy_o), 32'd1);
    @(posedge clk_i); #1 rd_ready_i = 1'b1;
    wait_done(400);
    repeat (4) @(negedge clk_i);
    chk("long_count", 32'(rq.size()), 32'd20);
    for (int i = 0; i < 20 && i < rq.size(); i++) chk("long_data", 32'(rq[i]), 32'hA000 + 32'(i));

    // Zero-length commands: len 0 and len 1.
    for (int k = 0; k < 2; k++) begin
      s = stb_cnt;
      send_cmd(1'b0, 32'h20, 16'(k));
      chk("zl_done", 32'(done_o), 32'd1);
      chk("zl_busy", 32'(busy_o), 32'd0);
      @(posedge clk_i); #1;
      chk("zl_done_pulse", 32'(done_o), 32'd0);
      chk("zl_no_stb", 32'(stb_cnt - s), 32'd0);
    end

    // Gapped producer: one word every 5 cycles.
    send_cmd(1'b0, 32'h80, 16'd10);
    for (int i = 0; i < 5; i++) begin
      push_wr(16'h5A00 + 16'(i));
      repeat (3) @(negedge clk_i);
    end
    wait_done(200);
    for (int i = 0; i < 5; i++) chk("gap_ram", 32'(ram[64 + i]), 32'h5A00 + 32'(i));

    // Reset while a 6-word read waits on a word.
    rq.delete();
    send_cmd(1'b1, 32'h40, 16'd12);
    for (int i = 0; i < 100 && !bus.bs_seq_o; i++) @(negedge clk_i);
    chk("rst_in_wait", 32'(bus.bs_seq_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("mid_rst_outs", 32'({busy_o, done_o, rd_valid_o, bus.bs_stb_o, bus.bs_seq_o}), 32'd0);
    chk("mid_rst_addr", bus.bs_addr_o, 32'd0);
    chk("mid_rst_dat", 32'(bus.bs_dat_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    rq.delete();
    send_cmd(1'b1, 32'h10, 16'd8);
    wait_done(200);
    repeat (4) @(negedge clk_i);
    chk("post_rst_count", 32'(rq.size()), 32'd4);
    for (int i = 0; i < 4 && i < rq.size(); i++) chk("post_rst_data", 32'(rq[i]), 32'h1111 * 32'(i + 1));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
